// File: rtl/decoder_3to8_pkg.sv
// Shared widths and the idle (all-outputs-high) value for the registered 3-to-8 decoder.
package decoder_3to8_pkg;

    localparam int SEL_W = 3;
    localparam int OUT_W = 8;

    localparam logic [OUT_W-1:0] Y_IDLE = 8'hFF;

endpackage : decoder_3to8_pkg

// File: rtl/decoder_3to8_core.sv
// Combinational one-cold decode: the selected line goes low only when enabled.
module decoder_3to8_core
    import decoder_3to8_pkg::*;
(
    input  logic             en,
    input  logic [SEL_W-1:0] idx,
    output logic [OUT_W-1:0] y_n
);

    logic [OUT_W-1:0] one_hot;

    always_comb begin
        one_hot = {{(OUT_W-1){1'b0}}, 1'b1} << idx;
        y_n     = en ? ~one_hot : Y_IDLE;
    end

endmodule : decoder_3to8_core

// File: rtl/decoder_3to8.sv
// 74x138-style registered decoder: three enables, three address bits, eight
// active-low outputs driven straight from a flop so the strobe bus is glitch-free.
module decoder_3to8
    import decoder_3to8_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic E1_n,
    input  logic E2_n,
    input  logic E3,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    output logic Y0_n,
    output logic Y1_n,
    output logic Y2_n,
    output logic Y3_n,
    output logic Y4_n,
    output logic Y5_n,
    output logic Y6_n,
    output logic Y7_n
);

    // No handshake: inputs are sampled on every rising edge and the decode
    // appears on the outputs exactly one edge later.
    logic             en;
    logic [SEL_W-1:0] idx;
    logic [OUT_W-1:0] y_n_next;
    logic [OUT_W-1:0] y_n_q;

    assign en  = ~E1_n & ~E2_n & E3;
    assign idx = {A2, A1, A0};

    decoder_3to8_core u_core (
        .en  (en),
        .idx (idx),
        .y_n (y_n_next)
    );

    // Reset wins over any enable/address combination on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_n_q <= Y_IDLE;
        end else begin
            y_n_q <= y_n_next;
        end
    end

    a_one_cold: assert property (@(posedge clk) disable iff (rst) $countones(~y_n_q) <= 1);

    assign Y0_n = y_n_q[0];
    assign Y1_n = y_n_q[1];
    assign Y2_n = y_n_q[2];
    assign Y3_n = y_n_q[3];
    assign Y4_n = y_n_q[4];
    assign Y5_n = y_n_q[5];
    assign Y6_n = y_n_q[6];
    assign Y7_n = y_n_q[7];

endmodule : decoder_3to8

// File: tb/tb_decoder_3to8.sv
// Directed-vector bench for the registered 3-to-8 decoder with hand-computed expected buses.
module tb_decoder_3to8;

    logic clk;
    logic rst;
    logic E1_n, E2_n, E3;
    logic A0, A1, A2;
    logic Y0_n, Y1_n, Y2_n, Y3_n, Y4_n, Y5_n, Y6_n, Y7_n;
    logic [7:0] bus;

    int n_cmp;
    int n_bad;

    // Expected bus for A = 0..7 with all enables active.
    logic [7:0] sweep_exp [8];

    decoder_3to8 dut (
        .clk  (clk),
        .rst  (rst),
        .E1_n (E1_n),
        .E2_n (E2_n),
        .E3   (E3),
        .A0   (A0),
        .A1   (A1),
        .A2   (A2),
        .Y0_n (Y0_n),
        .Y1_n (Y1_n),
        .Y2_n (Y2_n),
        .Y3_n (Y3_n),
        .Y4_n (Y4_n),
        .Y5_n (Y5_n),
        .Y6_n (Y6_n),
        .Y7_n (Y7_n)
    );

    assign bus = {Y7_n, Y6_n, Y5_n, Y4_n, Y3_n, Y2_n, Y1_n, Y0_n};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic r, input logic e1n, input logic e2n,
                          input logic e3, input logic [2:0] a);
        rst  = r;
        E1_n = e1n;
        E2_n = e2n;
        E3   = e3;
        {A2, A1, A0} = a;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        n_cmp++;
        assert (bus === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, bus, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        sweep_exp[0] = 8'b1111_1110;
        sweep_exp[1] = 8'b1111_1101;
        sweep_exp[2] = 8'b1111_1011;
        sweep_exp[3] = 8'b1111_0111;
        sweep_exp[4] = 8'b1110_1111;
        sweep_exp[5] = 8'b1101_1111;
        sweep_exp[6] = 8'b1011_1111;
        sweep_exp[7] = 8'b0111_1111;

        // Reset held for two edges with a live enable and address.
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 3'b100);
        tick();
        check("reset_edge1", 8'hFF);
        tick();
        check("reset_edge2", 8'hFF);

        // Release: first decode lands on the following edge.
        rst = 1'b0;
        #1;
        check("release_no_early", 8'hFF);
        tick();
        check("after_release_a4", 8'b1110_1111);

        set_in(1'b0, 1'b0, 1'b0, 1'b1, 3'b110);
        #1;
        check("latency_hold_a4", 8'b1110_1111);
        tick();
        check("decode_a6", 8'b1011_1111);

        set_in(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
        tick();
        check("decode_a0", 8'b1111_1110);

        // Each disable on its own, re-enabling in between.
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 3'b100);
        tick();
        check("dis_e2n", 8'hFF);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 3'b100);
        tick();
        check("reen_a4_1", 8'b1110_1111);
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 3'b100);
        tick();
        check("dis_e1n", 8'hFF);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 3'b100);
        tick();
        check("reen_a4_2", 8'b1110_1111);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
        tick();
        check("dis_e3", 8'hFF);
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 3'b111);
        tick();
        check("dis_all_a7", 8'hFF);

        // Full address sweep with reset dropped in at A=5.
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b1, 3'(i));
            tick();
            check($sformatf("sweep_a%0d", i), sweep_exp[i]);
            if (i == 5) begin
                rst = 1'b1;
                tick();
                check("sweep_mid_reset", 8'hFF);
                rst = 1'b0;
                tick();
                check("sweep_after_reset_a5", sweep_exp[5]);
            end
        end

        // Reset priority over an active decode (Y7 low -> idle on same edge).
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 3'b010);
        tick();
        check("reset_over_active", 8'hFF);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 3'b010);
        tick();
        check("decode_a2", 8'b1111_1011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_decoder_3to8
